// File: rtl/avr109_loader.sv
// AVR109 (butterfly protocol) boot loader engine: attach sequence, command decode, flash/EEPROM block access.
// Optional chip erase command 'e' is built when AVR109_LOADER_ERASE_EN is defined; otherwise 'e' answers '?'.
module avr109_loader #(
  parameter int unsigned ADDR_WIDTH    = 16,
  parameter int unsigned EE_ADDR_WIDTH = 10,
  parameter int unsigned BLOCK_SIZE    = 256,
  parameter int unsigned ATTACH_PAIRS  = 3,
  parameter logic [23:0] SIGNATURE     = 24'h1E9502,
  parameter logic [7:0]  VERSION_HIGH  = 8'h31,
  parameter logic [7:0]  VERSION_LOW   = 8'h31
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_data,
  input  logic                     rx_avail,
  input  logic                     tx_ready,
  output logic [7:0]               tx_data,
  output logic                     tx_avail,
  output logic                     intercept_mode,
  output logic                     prog_mode,
  output logic [ADDR_WIDTH-1:0]    prog_addr,
  output logic [15:0]              prog_data,
  input  logic [15:0]              prog_data_in,
  output logic                     prog_low,
  output logic                     prog_high,
  output logic [EE_ADDR_WIDTH-1:0] ee_addr,
  output logic [7:0]               ee_data,
  output logic                     ee_we,
  input  logic [7:0]               ee_data_in
);

  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_ESC = 8'h1B;
  localparam logic [7:0] CH_AA  = 8'hAA;
  localparam logic [7:0] CH_Q   = 8'h3F;
  localparam logic [7:0] CH_Y   = 8'h59;
  localparam logic [7:0] CH_F   = 8'h46;
  localparam logic [7:0] CH_E   = 8'h45;
  localparam logic [15:0] BS16  = 16'(BLOCK_SIZE);

  typedef enum logic [3:0] {
    S_INACTIVE,
    S_ATTACH,
    S_IDLE,
    S_ARGS,
    S_WDATA,
    S_RDATA,
    S_ADV,
    S_REPLY
`ifdef AVR109_LOADER_ERASE_EN
    , S_ERASE
`endif
  } state_t;

  state_t                  state, state_n;
  logic [ADDR_WIDTH-1:0]   waddr, waddr_n;
  logic                    phase, phase_n;
  logic [15:0]             cnt, cnt_n;
  logic [15:0]             att_cnt, att_cnt_n;
  logic [7:0]              cmd, cmd_n;
  logic [1:0]              argc, argc_n;
  logic [1:0]              argi, argi_n;
  logic [7:0]              args [2];
  logic [7:0]              args_n [2];
  logic [7:0]              rbuf [3];
  logic [7:0]              rbuf_n [3];
  logic [1:0]              rlen, rlen_n;
  logic [1:0]              ridx, ridx_n;
  logic                    ret_inactive, ret_inactive_n;
  logic                    blk_ee, blk_ee_n;
  logic                    blk_rd, blk_rd_n;
  logic                    prog_mode_n;
  logic [7:0]              tx_data_n;
  logic                    tx_avail_n;

  logic                    send_ok;
  logic                    rep, rinact;
  logic [1:0]              rl;
  logic [7:0]              r0, r1, r2;
  logic [15:0]             hdr_cnt;
  logic                    hdr_bad;

  assign send_ok        = tx_ready & ~tx_avail;
  assign intercept_mode = (state != S_INACTIVE) && (state != S_ATTACH);
  assign prog_addr      = waddr;
  assign ee_addr        = waddr[EE_ADDR_WIDTH-1:0];
  assign ee_data        = rx_data;
  assign hdr_cnt        = {args[0], args[1]};
  assign hdr_bad        = (32'(hdr_cnt) > BLOCK_SIZE) || !((rx_data == CH_F) || (rx_data == CH_E));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_INACTIVE;
      waddr        <= '0;
      phase        <= 1'b0;
      cnt          <= '0;
      att_cnt      <= '0;
      cmd          <= '0;
      argc         <= '0;
      argi         <= '0;
      args[0]      <= '0;
      args[1]      <= '0;
      rbuf[0]      <= '0;
      rbuf[1]      <= '0;
      rbuf[2]      <= '0;
      rlen         <= '0;
      ridx         <= '0;
      ret_inactive <= 1'b0;
      blk_ee       <= 1'b0;
      blk_rd       <= 1'b0;
      prog_mode    <= 1'b0;
      tx_data      <= '0;
      tx_avail     <= 1'b0;
    end else begin
      state        <= state_n;
      waddr        <= waddr_n;
      phase        <= phase_n;
      cnt          <= cnt_n;
      att_cnt      <= att_cnt_n;
      cmd          <= cmd_n;
      argc         <= argc_n;
      argi         <= argi_n;
      args[0]      <= args_n[0];
      args[1]      <= args_n[1];
      rbuf[0]      <= rbuf_n[0];
      rbuf[1]      <= rbuf_n[1];
      rbuf[2]      <= rbuf_n[2];
      rlen         <= rlen_n;
      ridx         <= ridx_n;
      ret_inactive <= ret_inactive_n;
      blk_ee       <= blk_ee_n;
      blk_rd       <= blk_rd_n;
      prog_mode    <= prog_mode_n;
      tx_data      <= tx_data_n;
      tx_avail     <= tx_avail_n;
    end
  end

  always_comb begin
    state_n        = state;
    waddr_n        = waddr;
    phase_n        = phase;
    cnt_n          = cnt;
    att_cnt_n      = att_cnt;
    cmd_n          = cmd;
    argc_n         = argc;
    argi_n         = argi;
    args_n[0]      = args[0];
    args_n[1]      = args[1];
    rbuf_n[0]      = rbuf[0];
    rbuf_n[1]      = rbuf[1];
    rbuf_n[2]      = rbuf[2];
    rlen_n         = rlen;
    ridx_n         = ridx;
    ret_inactive_n = ret_inactive;
    blk_ee_n       = blk_ee;
    blk_rd_n       = blk_rd;
    prog_mode_n    = prog_mode;
    tx_data_n      = tx_data;
    tx_avail_n     = 1'b0;
    prog_low       = 1'b0;
    prog_high      = 1'b0;
    ee_we          = 1'b0;
    prog_data      = {rx_data, rx_data};
    rep            = 1'b0;
    rinact         = 1'b0;
    rl             = 2'd1;
    r0             = CH_CR;
    r1             = 8'h00;
    r2             = 8'h00;

    unique case (state)
      S_INACTIVE: begin
        att_cnt_n = '0;
        if (rx_avail && rx_data == CH_ESC)
          state_n = (ATTACH_PAIRS == 0) ? S_IDLE : S_ATTACH;
      end

      // Even positions expect 0xAA, odd positions 0x1B.
      S_ATTACH: begin
        if (rx_avail) begin
          if (rx_data == (att_cnt[0] ? CH_ESC : CH_AA)) begin
            att_cnt_n = att_cnt + 16'd1;
            if (32'(att_cnt) == 2 * ATTACH_PAIRS - 1)
              state_n = S_IDLE;
          end else begin
            state_n     = S_INACTIVE;
            prog_mode_n = 1'b0;
          end
        end
      end

      S_IDLE: begin
        if (rx_avail) begin
          cmd_n  = rx_data;
          argi_n = '0;
          case (rx_data)
            CH_LF, CH_ESC: ;
            8'h41: begin argc_n = 2'd2; state_n = S_ARGS; end
            8'h48, 8'h42, 8'h67: begin argc_n = 2'd3; state_n = S_ARGS; end
            8'h54: begin argc_n = 2'd1; state_n = S_ARGS; end
            8'h50: begin prog_mode_n = 1'b1; rep = 1'b1; end
            8'h4C: begin prog_mode_n = 1'b0; rep = 1'b1; end
            8'h56: begin rep = 1'b1; rl = 2'd2; r0 = VERSION_HIGH; r1 = VERSION_LOW; end
            8'h61: begin rep = 1'b1; r0 = CH_Y; end
            8'h62: begin rep = 1'b1; rl = 2'd3; r0 = CH_Y; r1 = BS16[15:8]; r2 = BS16[7:0]; end
            8'h74: begin rep = 1'b1; r0 = 8'h00; end
            8'h73: begin
              rep = 1'b1; rl = 2'd3;
              r0 = SIGNATURE[7:0]; r1 = SIGNATURE[15:8]; r2 = SIGNATURE[23:16];
            end
            CH_E: begin rep = 1'b1; rinact = 1'b1; end
`ifdef AVR109_LOADER_ERASE_EN
            8'h65: begin waddr_n = '0; phase_n = 1'b0; state_n = S_ERASE; end
`endif
            default: begin rep = 1'b1; r0 = CH_Q; end
          endcase
        end
      end

      // The final argument byte is used live from rx_data rather than stored.
      S_ARGS: begin
        if (rx_avail) begin
          if (argi == argc - 2'd1) begin
            case (cmd)
              8'h41: begin
                waddr_n = ADDR_WIDTH'({8'h00, args[0], rx_data});
                phase_n = 1'b0;
                rep     = 1'b1;
              end
              8'h48: begin
                waddr_n = ADDR_WIDTH'({args[0], args[1], rx_data});
                phase_n = 1'b0;
                rep     = 1'b1;
              end
              8'h54: rep = 1'b1;
              default: begin
                blk_rd_n = (cmd == 8'h67);
                blk_ee_n = (rx_data == CH_E);
                if (hdr_bad) begin
                  rep = 1'b1;
                  r0  = CH_Q;
                end else if (hdr_cnt == 16'd0) begin
                  if (cmd == 8'h67) state_n = S_IDLE;
                  else              rep     = 1'b1;
                end else begin
                  cnt_n   = hdr_cnt;
                  state_n = (cmd == 8'h67) ? S_RDATA : S_WDATA;
                end
              end
            endcase
          end else begin
            args_n[argi[0]] = rx_data;
            argi_n          = argi + 2'd1;
          end
        end
      end

      S_WDATA: begin
        if (rx_avail) begin
          if (blk_ee)     ee_we     = 1'b1;
          else if (phase) prog_high = 1'b1;
          else            prog_low  = 1'b1;
          state_n = S_ADV;
        end
      end

      S_RDATA: begin
        if (send_ok) begin
          tx_avail_n = 1'b1;
          if (blk_ee)     tx_data_n = ee_data_in;
          else if (phase) tx_data_n = prog_data_in[15:8];
          else            tx_data_n = prog_data_in[7:0];
          state_n = S_ADV;
        end
      end

      S_ADV: begin
        if (blk_ee) begin
          waddr_n = waddr + ADDR_WIDTH'(1);
        end else begin
          phase_n = ~phase;
          if (phase) waddr_n = waddr + ADDR_WIDTH'(1);
        end
        cnt_n = cnt - 16'd1;
        if (cnt == 16'd1) begin
          if (blk_rd) state_n = S_IDLE;
          else        rep     = 1'b1;
        end else begin
          state_n = blk_rd ? S_RDATA : S_WDATA;
        end
      end

      S_REPLY: begin
        if (send_ok) begin
          tx_avail_n = 1'b1;
          tx_data_n  = rbuf[ridx];
          if (ridx == rlen - 2'd1) begin
            state_n = ret_inactive ? S_INACTIVE : S_IDLE;
            if (ret_inactive) prog_mode_n = 1'b0;
          end else begin
            ridx_n = ridx + 2'd1;
          end
        end
      end

`ifdef AVR109_LOADER_ERASE_EN
      S_ERASE: begin
        prog_low  = 1'b1;
        prog_high = 1'b1;
        prog_data = 16'hFFFF;
        waddr_n   = waddr + ADDR_WIDTH'(1);
        if (&waddr) rep = 1'b1;
      end
`endif

      default: state_n = S_INACTIVE;
    endcase

    if (rep) begin
      rbuf_n[0]      = r0;
      rbuf_n[1]      = r1;
      rbuf_n[2]      = r2;
      rlen_n         = rl;
      ridx_n         = '0;
      ret_inactive_n = rinact;
      state_n        = S_REPLY;
    end
  end

endmodule

// File: tb/tb_avr109_loader.sv
// Directed bench for avr109_loader: attach, flash/EEPROM block transfers, replies, errors, erase, reset abort.
module tb_avr109_loader;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_avail;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        tx_avail;
  logic        intercept_mode;
  logic        prog_mode;
  logic [11:0] prog_addr;
  logic [15:0] prog_data;
  logic [15:0] prog_data_in;
  logic        prog_low;
  logic        prog_high;
  logic [9:0]  ee_addr;
  logic [7:0]  ee_data;
  logic        ee_we;
  logic [7:0]  ee_data_in;

  int nchk  = 0;
  int nfail = 0;

  logic [7:0]  txq [$];
  logic [34:0] stq [$];

  always #5 clk = ~clk;

  avr109_loader #(.ADDR_WIDTH(12), .EE_ADDR_WIDTH(10)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_avail(rx_avail), .tx_ready(tx_ready),
    .tx_data(tx_data), .tx_avail(tx_avail), .intercept_mode(intercept_mode),
    .prog_mode(prog_mode), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_data_in(prog_data_in), .prog_low(prog_low), .prog_high(prog_high),
    .ee_addr(ee_addr), .ee_data(ee_data), .ee_we(ee_we), .ee_data_in(ee_data_in)
  );

  assign prog_data_in = (prog_addr == 12'h010) ? 16'h2211 :
                        (prog_addr == 12'h011) ? 16'h4433 : 16'hC0DE;
  assign ee_data_in   = 8'h50 + ee_addr[7:0];

  // Record {low,high,we,addr,data} of every strobe and every transmitted byte.
  always @(negedge clk) begin
    if (tx_avail) txq.push_back(tx_data);
    if (prog_low | prog_high | ee_we)
      stq.push_back({prog_low, prog_high, ee_we,
                     ee_we ? 16'(ee_addr) : 16'(prog_addr),
                     ee_we ? {8'h00, ee_data} : prog_data});
  end

  function automatic logic [34:0] rec(input logic [2:0] l, input logic [15:0] a, input logic [15:0] d);
    return {l, a, d};
  endfunction

  function automatic logic [34:0] pop_s();
    if (stq.size() == 0) return '1;
    return stq.pop_front();
  endfunction

  function automatic logic [8:0] pop_t();
    if (txq.size() == 0) return 9'h1FF;
    return {1'b0, txq.pop_front()};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic etx(input string tag, input logic [7:0] e);
    chk(tag, 64'(pop_t()), {56'h0, e});
  endtask

  task automatic est(input string tag, input logic [34:0] e);
    chk(tag, 64'(pop_s()), 64'(e));
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_avail = 1'b1;
    @(posedge clk); #1;
    rx_avail = 1'b0;
    repeat (8) @(posedge clk);
  endtask

  task automatic cmd(input int n, input logic [7:0] b0, input logic [7:0] b1 = 8'h00,
                     input logic [7:0] b2 = 8'h00, input logic [7:0] b3 = 8'h00);
    send(b0);
    if (n > 1) send(b1);
    if (n > 2) send(b2);
    if (n > 3) send(b3);
  endtask

  initial begin
    int cnt;
    logic ok;
    logic [34:0] r;
    logic [34:0] last;

    rst = 1'b1; rx_data = 8'h00; rx_avail = 1'b0; tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {intercept_mode, prog_mode, tx_avail, prog_low, prog_high, ee_we, prog_addr, tx_data},
        64'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    cmd(3, 8'h1B, 8'hAA, 8'h55);
    chk("attach_mismatch", 64'(intercept_mode), 64'h0);
    cmd(4, 8'h1B, 8'hAA, 8'h1B, 8'hAA);
    cmd(2, 8'h1B, 8'hAA);
    chk("attach_partial", 64'(intercept_mode), 64'h0);
    send(8'h1B);
    chk("attach_done", 64'(intercept_mode), 64'h1);
    chk("attach_no_tx", 64'(txq.size()), 64'h0);

    // Flash write of three bytes from an even phase
    send(8'h50);
    etx("P_cr", 8'h0D);
    chk("prog_mode_set", 64'(prog_mode), 64'h1);
    cmd(3, 8'h41, 8'h00, 8'h10);
    etx("A_cr", 8'h0D);
    chk("A_addr", 64'(prog_addr), 64'h010);
    cmd(4, 8'h42, 8'h00, 8'h03, 8'h46);
    cmd(3, 8'h11, 8'h22, 8'h33);
    est("wr_low_10", rec(3'b100, 16'h0010, 16'h1111));
    est("wr_high_10", rec(3'b010, 16'h0010, 16'h2222));
    est("wr_low_11", rec(3'b100, 16'h0011, 16'h3333));
    etx("B_cr", 8'h0D);
    chk("B_addr_after", 64'(prog_addr), 64'h011);
    // Odd phase persists into the next block
    cmd(4, 8'h42, 8'h00, 8'h01, 8'h46);
    send(8'h44);
    est("wr_odd_high_11", rec(3'b010, 16'h0011, 16'h4444));
    etx("B2_cr", 8'h0D);
    chk("B2_addr_after", 64'(prog_addr), 64'h012);

    cmd(3, 8'h41, 8'h00, 8'h10);
    etx("A2_cr", 8'h0D);
    cmd(4, 8'h67, 8'h00, 8'h04, 8'h46);
    repeat (6) @(posedge clk);
    etx("rd_b0", 8'h11);
    etx("rd_b1", 8'h22);
    etx("rd_b2", 8'h33);
    etx("rd_b3", 8'h44);
    chk("rd_no_cr", 64'(txq.size()), 64'h0);

    cmd(3, 8'h41, 8'h00, 8'h05);
    etx("A3_cr", 8'h0D);
    cmd(4, 8'h42, 8'h00, 8'h02, 8'h45);
    cmd(2, 8'hAA, 8'hBB);
    est("ee_wr_5", rec(3'b001, 16'h0005, 16'h00AA));
    est("ee_wr_6", rec(3'b001, 16'h0006, 16'h00BB));
    etx("Be_cr", 8'h0D);
    cmd(3, 8'h41, 8'h00, 8'h05);
    etx("A4_cr", 8'h0D);
    cmd(4, 8'h67, 8'h00, 8'h02, 8'h45);
    etx("ee_rd_5", 8'h55);
    etx("ee_rd_6", 8'h56);

    cmd(4, 8'h42, 8'h01, 8'h01, 8'h46);
    etx("B_too_big", 8'h3F);
    cmd(4, 8'h67, 8'h00, 8'h01, 8'h58);
    etx("g_bad_type", 8'h3F);
    send(8'h5A);
    etx("unknown_cmd", 8'h3F);
    send(8'h73);
    etx("sig0", 8'h02); etx("sig1", 8'h95); etx("sig2", 8'h1E);
    send(8'h62);
    etx("blk0", 8'h59); etx("blk1", 8'h01); etx("blk2", 8'h00);
    send(8'h56);
    etx("ver_hi", 8'h31); etx("ver_lo", 8'h31);
    send(8'h61);
    etx("autoinc", 8'h59);
    send(8'h74);
    etx("devtype", 8'h00);
    cmd(2, 8'h54, 8'h77);
    etx("T_cr", 8'h0D);
    cmd(4, 8'h67, 8'h00, 8'h00, 8'h46);
    chk("g_zero_silent", 64'(txq.size()), 64'h0);
    cmd(4, 8'h42, 8'h00, 8'h00, 8'h45);
    etx("B_zero_cr", 8'h0D);
    chk("no_stray_strobes", 64'(stq.size()), 64'h0);

    cmd(4, 8'h48, 8'h01, 8'h23, 8'h45);
    etx("H_cr", 8'h0D);
    chk("H_trunc_addr", 64'(prog_addr), 64'h345);
    cmd(3, 8'h41, 8'h0F, 8'hFF);
    etx("A5_cr", 8'h0D);
    cmd(4, 8'h42, 8'h00, 8'h02, 8'h46);
    cmd(2, 8'h12, 8'h34);
    est("wrap_low", rec(3'b100, 16'h0FFF, 16'h1212));
    est("wrap_high", rec(3'b010, 16'h0FFF, 16'h3434));
    etx("wrap_cr", 8'h0D);
    chk("wrap_addr", 64'(prog_addr), 64'h000);

    send(8'h65);
`ifdef AVR109_LOADER_ERASE_EN
    for (int i = 0; i < 6000 && txq.size() == 0; i++) @(posedge clk);
    chk("erase_count", 64'(stq.size()), 64'd4096);
    cnt = 0;
    ok  = 1'b1;
    last = '0;
    while (stq.size() > 0) begin
      r = stq.pop_front();
      if (r != rec(3'b110, 16'(cnt), 16'hFFFF)) ok = 1'b0;
      last = r;
      cnt++;
    end
    chk("erase_words", 64'(ok), 64'h1);
    chk("erase_last", 64'(last), 64'(rec(3'b110, 16'h0FFF, 16'hFFFF)));
    etx("erase_cr", 8'h0D);
    chk("erase_addr_wrapped", 64'(prog_addr), 64'h000);
`else
    etx("erase_disabled", 8'h3F);
    chk("erase_no_strobe", 64'(stq.size()), 64'h0);
`endif

    send(8'h45);
    etx("exit_cr", 8'h0D);
    chk("exit_state", {62'h0, intercept_mode, prog_mode}, 64'h0);

    // Reset mid-transfer while a data byte is presented
    cmd(4, 8'h1B, 8'hAA, 8'h1B, 8'hAA);
    cmd(3, 8'h1B, 8'hAA, 8'h1B);
    cmd(4, 8'h42, 8'h00, 8'h02, 8'h45);
    send(8'h99);
    est("pre_abort_ee", rec(3'b001, 16'h0000, 16'h0099));
    @(posedge clk); #1;
    rst = 1'b1; rx_data = 8'hBB; rx_avail = 1'b1;
    @(negedge clk);
    chk("abort_outputs", {ee_we, prog_low, prog_high, intercept_mode, tx_avail, prog_addr}, 64'h0);
    @(posedge clk); #1;
    rx_avail = 1'b0; rst = 1'b0;
    repeat (4) @(posedge clk);
    chk("abort_no_strobe", 64'(stq.size()), 64'h0);
    chk("abort_inactive", 64'(intercept_mode), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/avr109_loader.md
Name: avr109_loader

Overview:
- Parametrised second-generation AVR109 (butterfly-protocol) boot loader engine.
- Operates on a byte stream from an external UART: rx strobe in, tx handshake out.
- Drives the program-memory write/read port (16-bit words) and an EEPROM byte port.
- Adds over the first generation: wide addresses, 16-bit block counts, EEPROM block access, signature reply, configurable attach sequence, optional chip erase.

Parameters:
- ADDR_WIDTH, 16: flash word-address width; waddr register width.
- EE_ADDR_WIDTH, 10: EEPROM byte-address width.
- BLOCK_SIZE, 256: maximum block byte count; reported by 'b'.
- ATTACH_PAIRS, 3: number of (0xAA,0x1B) pairs following the initial 0x1B.
- SIGNATURE, 24'h1E9502: device signature; sent low byte first on 's'.
- VERSION_HIGH / VERSION_LOW, "1" / "1": 'V' reply bytes.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- rx_data  in  8  received byte; valid with rx_avail.
- rx_avail  in  1  one-cycle strobe per received byte.
- tx_ready  in  1  transmitter idle.
- tx_data  out  8  byte to send; registered.
- tx_avail  out  1  one-cycle send strobe; registered.
- intercept_mode  out  1  high in every state from IDLE onward.
- prog_mode  out  1  set by 'P', cleared by 'L' and on entry to INACTIVE.
- prog_addr  out  ADDR_WIDTH  flash word address (waddr).
- prog_data  out  16  {rx_data,rx_data}; 16'hFFFF during erase.
- prog_data_in  in  16  flash read data for prog_addr; combinational, same cycle.
- prog_low / prog_high  out  1  flash byte-lane write strobes.
- ee_addr  out  EE_ADDR_WIDTH  waddr[EE_ADDR_WIDTH-1:0].
- ee_data  out  8  rx_data.
- ee_we  out  1  EEPROM byte write strobe.
- ee_data_in  in  8  EEPROM read data for ee_addr; combinational.

Behaviour:
- Reset: state INACTIVE; all outputs 0; waddr 0; phase 0; cnt 0.
- send_ok = tx_ready & ~tx_avail. Every reply byte waits for send_ok, so at most one tx_avail pulse per two cycles.
- INACTIVE -> ATTACHING on 0x1B.
- ATTACHING expects alternately 0xAA, 0x1B for 2*ATTACH_PAIRS bytes, then goes to IDLE. Any mismatch returns to INACTIVE, mismatching byte discarded.
- IDLE commands; 0x0A and 0x1B are ignored:
  - 'A' hi lo: waddr={hi,lo} zero-extended, phase=0, reply CR (0x0D).
  - 'H' ext hi lo: waddr={ext,hi,lo} truncated to ADDR_WIDTH, phase=0, reply CR.
  - 'P' / 'L': set / clear prog_mode, reply CR.
  - 'T' x: ignore x, reply CR.
  - 'V': reply VERSION_HIGH, VERSION_LOW.
  - 'a': reply 'Y'.
  - 'b': reply 'Y', BLOCK_SIZE[15:8], BLOCK_SIZE[7:0].
  - 't': reply 0x00.
  - 's': reply SIGNATURE[7:0], [15:8], [23:16].
  - 'E': reply CR, wait send_ok, then INACTIVE.
  - 'B' / 'g': see block transfers below.
  - Anything else: reply '?' (0x3F), return to IDLE.
- 'B' ch cl m (block write):
  - cnt={ch,cl}.
  - cnt>BLOCK_SIZE, or m not 'F'/'E': reply '?'.
  - Otherwise cnt data bytes follow; cnt=0 replies CR at once.
  - F: byte with phase=0 pulses prog_low; phase=1 pulses prog_high. Strobe in the cycle rx_avail is seen. Next cycle: phase toggles; waddr+1 after the high byte.
  - E: pulses ee_we, then waddr+1.
  - After the last byte, reply CR.
- 'g' ch cl m (block read):
  - Same count and type checks as 'B'.
  - F: send prog_data_in[7:0] when phase=0, [15:8] when phase=1, then advance as for write.
  - E: send ee_data_in, then waddr+1.
  - No trailing CR; cnt=0 returns to IDLE silently.
- Each data byte takes one strobe/send cycle plus one advance cycle.
- waddr wraps modulo 2^ADDR_WIDTH. An odd-phase start persists across blocks until 'A'/'H'.
- rx_avail is ignored in reply and advance states. The host is half-duplex per protocol.
- rst asserted mid-transfer aborts immediately to reset values. No strobe is issued in or after the reset cycle.

Optional Feature:
- Macro: AVR109_LOADER_ERASE_EN.
- Defined, 'e':
  - waddr=0, phase=0.
  - Each cycle asserts prog_low and prog_high with prog_data=16'hFFFF at prog_addr, then waddr+1.
  - After word 2^ADDR_WIDTH-1 (2^ADDR_WIDTH cycles), waddr has wrapped to 0; reply CR, return to IDLE.
- Undefined: 'e' replies '?'. No erase state exists.

Test Plan:
- Attach: reset, send 1B AA 1B AA 1B AA 1B -> intercept_mode=1 after the last byte. Then 1B AA 55 from INACTIVE -> stays 0.
- Flash write: 'P', 'A' 00 10, 'B' 00 03 'F' 11 22 33 -> prog_low@0x10 data 11, prog_high@0x10 data 22, prog_low@0x11 data 33; replies CR,CR,CR; waddr=0x11, phase=1.
- Flash read: 'A' 00 10, 'g' 00 04 'F' with memory 0x10=2211, 0x11=4433 -> tx 11 22 33 44, no CR.
- EEPROM write/read: 'A' 00 05, 'B' 00 02 'E' AA BB -> ee_we at ee_addr 5 then 6; then 'g' 00 02 'E' from addr 5 -> echoes ee_data_in.
- Errors: 'B' 01 01 'F' (257>256) -> '?'; 'g' 00 01 'X' -> '?'; 'Z' -> '?'; 's' -> 02 95 1E; 'b' -> 59 01 00.
- Erase, ADDR_WIDTH=4 with macro: 'e' -> 16 consecutive write cycles, addresses 0..15, data FFFF, then CR. Without macro -> '?'.
